// File: rtl/pea_pkg.sv
// Shared PE-array constants plus the state and operation types of the radix divider.
package pea_pkg;

  localparam int N_BITS  = 32;
  localparam int N_RADIX = 4;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } r_div_state_t;

  typedef enum logic {
    DIV_QUOT,
    DIV_REM
  } r_div_op_t;

endpackage

// File: rtl/r_div_stage.sv
// One radix-N_RADIX restoring step: retires log2(N_RADIX) quotient bits per call.
module r_div_stage
  import pea_pkg::*;
#(
  parameter int W = N_BITS,
  parameter int L = $clog2(N_RADIX)
) (
  input  logic [L-1:0] n_i,
  input  logic [W-1:0] r_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] r_o,
  output logic [L-1:0] q_o
);

  logic [W:0]   w_trial;
  logic [W-1:0] w_rem;

  // The remainder always stays below d_i, so one extra bit holds every shifted trial value.
  always_comb begin
    w_rem   = r_i;
    w_trial = '0;
    q_o     = '0;
    for (int k = L - 1; k >= 0; k--) begin
      w_trial = {w_rem, n_i[k]};
      if (w_trial >= {1'b0, d_i}) begin
        w_trial = w_trial - {1'b0, d_i};
        q_o[k]  = 1'b1;
      end
      w_rem = w_trial[W-1:0];
    end
    r_o = w_rem;
  end

endmodule

// File: rtl/r_div_ctrl.sv
// Multicycle sequencer for the restoring radix divider with sign and zero fix-up.
// Signed support (signed_i port, sign/overflow fix-up) is built only with MAGE_DIV_SIGNED_EN.
module r_div_ctrl
  import pea_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N_BITS-1:0] dividend_i,
  input  logic [N_BITS-1:0] divisor_i,
  input  logic              op_i,
`ifdef MAGE_DIV_SIGNED_EN
  input  logic              signed_i,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N_BITS-1:0] result_o,
  output logic              div_zero_o
);

  localparam int LOG2R  = $clog2(N_RADIX);
  localparam int N_ITER = N_BITS / LOG2R;
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [N_BITS-1:0] MOST_NEG = {1'b1, {(N_BITS - 1) {1'b0}}};

  r_div_state_t      r_state, w_state_nxt;
  r_div_op_t         r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_BITS-1:0] r_shift, r_rem, r_dreg, r_dividend, r_result;
  logic              r_zero, r_neg_q, r_neg_r, r_ovf, r_out_valid, r_div_zero;

  logic              w_in_fire;
  logic [N_BITS-1:0] w_dvd_abs, w_dvs_abs, w_stage_r, w_quot, w_remf, w_fix_result;
  logic [LOG2R-1:0]  w_stage_q;
  logic              w_neg_q, w_neg_r, w_ovf;

  assign in_ready_o  = (r_state == IDLE);
  assign w_in_fire   = in_valid_i & in_ready_o & ~flush_i;
  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;
  assign div_zero_o  = r_div_zero;

`ifdef MAGE_DIV_SIGNED_EN
  logic w_a_neg, w_b_neg;
  assign w_a_neg   = signed_i & dividend_i[N_BITS-1];
  assign w_b_neg   = signed_i & divisor_i[N_BITS-1];
  assign w_dvd_abs = w_a_neg ? -dividend_i : dividend_i;
  assign w_dvs_abs = w_b_neg ? -divisor_i : divisor_i;
  assign w_neg_q   = w_a_neg ^ w_b_neg;
  assign w_neg_r   = w_a_neg;
  assign w_ovf     = signed_i & (dividend_i == MOST_NEG) & (divisor_i == '1);
`else
  assign w_dvd_abs = dividend_i;
  assign w_dvs_abs = divisor_i;
  assign w_neg_q   = 1'b0;
  assign w_neg_r   = 1'b0;
  assign w_ovf     = 1'b0;
`endif

  r_div_stage #(
    .W(N_BITS),
    .L(LOG2R)
  ) u_stage (
    .n_i(r_shift[N_BITS-1 -: LOG2R]),
    .r_i(r_rem),
    .d_i(r_dreg),
    .r_o(w_stage_r),
    .q_o(w_stage_q)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // flush_i overrides every transition, including a same-cycle input handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_in_fire) w_state_nxt = (divisor_i == '0) ? FIX : ITER;
      ITER:    if (r_cnt == '0) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    if (out_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush_i) w_state_nxt = IDLE;
  end

  always_comb begin
    w_quot = r_neg_q ? -r_shift : r_shift;
    w_remf = r_neg_r ? -r_rem : r_rem;
    if (r_zero) begin
      w_quot = '1;
      w_remf = r_dividend;
    end else if (r_ovf) begin
      w_quot = MOST_NEG;
      w_remf = '0;
    end
    w_fix_result = (r_op == DIV_REM) ? w_remf : w_quot;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_op        <= DIV_QUOT;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rem       <= '0;
      r_dreg      <= '0;
      r_dividend  <= '0;
      r_zero      <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_ovf       <= 1'b0;
      r_result    <= '0;
      r_div_zero  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_shift    <= w_dvd_abs;
        r_dreg     <= w_dvs_abs;
        r_dividend <= dividend_i;
        r_op       <= r_div_op_t'(op_i);
        r_rem      <= '0;
        r_cnt      <= CNT_W'(N_ITER - 1);
        r_zero     <= (divisor_i == '0);
        r_neg_q    <= w_neg_q;
        r_neg_r    <= w_neg_r;
        r_ovf      <= w_ovf;
      end else if (r_state == ITER) begin
        r_rem   <= w_stage_r;
        r_shift <= {r_shift[N_BITS-LOG2R-1:0], w_stage_q};
        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      end

      if (flush_i) begin
        r_out_valid <= 1'b0;
      end else if (r_state == FIX) begin
        r_result    <= w_fix_result;
        r_div_zero  <= r_zero;
        r_out_valid <= 1'b1;
      end else if ((r_state == DONE) && out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_r_div_ctrl.sv
// Directed bench for r_div_ctrl; signed cases are compiled in with MAGE_DIV_SIGNED_EN.
module tb_r_div_ctrl;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        opIn = 1'b0;
`ifdef MAGE_DIV_SIGNED_EN
  logic        signedIn = 1'b0;
`endif
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] result;
  logic        divZero;

  int assertCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  r_div_ctrl dut (
    .clk_i      (clk),
    .rst_n_i    (rstN),
    .flush_i    (flush),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .op_i       (opIn),
`ifdef MAGE_DIV_SIGNED_EN
    .signed_i   (signedIn),
`endif
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .result_o   (result),
    .div_zero_o (divZero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs, input logic op);
    inValid  = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    opIn     = op;
    tick();
    inValid  = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!outValid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                       input logic op, input logic [31:0] expRes, input logic expZero,
                       input int expLat);
    int lat;
    applyStimulus(dvd, dvs, op);
    waitValid(lat);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_res"}, result, expRes);
    checkOutput({tag, "_zero"}, {31'b0, divZero}, {31'b0, expZero});
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  function automatic logic [31:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (b == 0) return op ? a : 32'hFFFF_FFFF;
    return op ? (a % b) : (a / b);
  endfunction

  initial begin
    int lat;
    int seen;
    logic [31:0] a, b;
    logic op;

    $display("[TB] reset checks");
    #2;
    checkOutput("rst_inReady", {31'b0, inReady}, 32'd1);
    checkOutput("rst_outValid", {31'b0, outValid}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_divZero", {31'b0, divZero}, 32'd0);
    tick();
    tick();
    rstN = 1'b1;
    tick();

    $display("[TB] basic unsigned and divide-by-zero");
    runOp("q100_7", 32'd100, 32'd7, 1'b0, 32'd14, 1'b0, 17);
    runOp("r100_7", 32'd100, 32'd7, 1'b1, 32'd2, 1'b0, 17);
    runOp("qdz", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1);
    runOp("rdz", 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678, 1'b1, 1);
    runOp("qmax", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b0, 17);
    runOp("rbig", 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b0, 17);

`ifdef MAGE_DIV_SIGNED_EN
    $display("[TB] signed cases");
    signedIn = 1'b1;
    runOp("sq_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 1'b0, 17);
    runOp("sr_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b0, 17);
    runOp("sq_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 17);
    runOp("sr_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 17);
    signedIn = 1'b0;
`endif

    $display("[TB] backpressure");
    applyStimulus(32'd1000, 32'd10, 1'b0);
    waitValid(lat);
    checkOutput("bp_lat", lat, 32'd17);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_result", result, 32'd100);
      checkOutput("bp_valid", {31'b0, outValid}, 32'd1);
      checkOutput("bp_inReady", {31'b0, inReady}, 32'd0);
      tick();
    end
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput("bp_rel_inReady", {31'b0, inReady}, 32'd1);
    checkOutput("bp_rel_valid", {31'b0, outValid}, 32'd0);

    $display("[TB] flush");
    applyStimulus(32'd50, 32'd5, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("fl_inReady", {31'b0, inReady}, 32'd1);
    checkOutput("fl_valid", {31'b0, outValid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (outValid) seen = 1;
      tick();
    end
    checkOutput("fl_noValid", seen, 32'd0);
    inValid  = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    flush    = 1'b1;
    tick();
    inValid  = 1'b0;
    flush    = 1'b0;
    checkOutput("fl_noAccept", {31'b0, inReady}, 32'd1);
    runOp("q9_3", 32'd9, 32'd3, 1'b0, 32'd3, 1'b0, 17);

    $display("[TB] reset mid-operation");
    runOp("pre_rst", 32'd1234, 32'd1, 1'b0, 32'd1234, 1'b0, 17);
    applyStimulus(32'd1000, 32'd3, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    rstN = 1'b0;
    #1;
    checkOutput("mr_inReady", {31'b0, inReady}, 32'd1);
    checkOutput("mr_valid", {31'b0, outValid}, 32'd0);
    checkOutput("mr_result", result, 32'd0);
    checkOutput("mr_divZero", {31'b0, divZero}, 32'd0);
    tick();
    rstN = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (outValid) seen = 1;
      tick();
    end
    checkOutput("mr_noValid", seen, 32'd0);

    $display("[TB] random stream");
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      case (i % 3)
        0:       b = $urandom_range(1, 255);
        1:       b = $urandom;
        default: b = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      op = i[0];
      runOp($sformatf("rnd%0d", i), a, b, op, refDiv(a, b, op), (b == 0), (b == 0) ? 1 : 17);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
